// File: rtl/game_pkg.sv
// Shared encodings for the game flow controller: StateMachine state codes,
// controller states, command codes and default game constants.
package game_pkg;

    localparam logic [1:0] SM_IDLE  = 2'b00;
    localparam logic [1:0] SM_PLAY  = 2'b01;
    localparam logic [1:0] SM_PAUSE = 2'b10;
    localparam logic [1:0] SM_DEAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HOLD,
        RESPAWN,
        OVER
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_START,
        CMD_PAUSE,
        CMD_RESUME,
        CMD_DIE
    } cmd_t;

    localparam int DEF_LIVES         = 3;
    localparam int DEF_ROUND_TIME    = 60;
    localparam int DEF_RESPAWN_TICKS = 3;

    // StateMachine code the controller expects to see for each of its states.
    function automatic logic [1:0] expected_sm(input ctrl_state_t s);
        case (s)
            IDLE:    return SM_IDLE;
            RUN:     return SM_PLAY;
            HOLD:    return SM_PAUSE;
            default: return SM_DEAD;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a registered rising-edge
// strobe; a held button yields a single one-cycle strobe.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic strobe
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            strobe <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            sync3  <= sync2;
            strobe <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: turns button/collision/timebase events into single
// cycle StateMachine commands, owns lives/round/respawn counters, flags desync.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int LIVES         = DEF_LIVES,
    parameter int ROUND_TIME    = DEF_ROUND_TIME,
    parameter int RESPAWN_TICKS = DEF_RESPAWN_TICKS,
    parameter int TW            = 8,
    parameter int LW            = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_start,
    input  logic          btn_pause,
    input  logic          hit,
    input  logic          tick,
    input  logic [1:0]    sm_state,
    output logic          start,
    output logic          pause,
    output logic          resume,
    output logic          die,
    output logic [LW-1:0] lives,
    output logic [TW-1:0] time_left,
    output logic          game_over,
    output logic          sync_err,
    output ctrl_state_t   dbg_state
);

    localparam int RW = $clog2(RESPAWN_TICKS + 1);

    logic se;
    logic pe;

    btn_edge u_start_edge (.clk(clk), .reset(reset), .raw(btn_start), .strobe(se));
    btn_edge u_pause_edge (.clk(clk), .reset(reset), .raw(btn_pause), .strobe(pe));

    ctrl_state_t   state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [TW-1:0] time_q, time_d;
    logic [RW-1:0] resp_q, resp_d;
    logic [1:0]    mask_q;
    logic          sync_err_q;
    logic          masked;
    logic [1:0]    exp_sm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_NONE;
            lives_q    <= '0;
            time_q     <= '0;
            resp_q     <= '0;
            mask_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            resp_q  <= resp_d;
            // Mask covers the pulse cycle plus the two cycles the StateMachine needs to follow.
            if (cmd_q != CMD_NONE) begin
                mask_q <= 2'd2;
            end else if (mask_q != 2'd0) begin
                mask_q <= mask_q - 2'd1;
            end
            sync_err_q <= sync_err_q | (!masked && (sm_state != exp_sm));
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_NONE;
        lives_d = lives_q;
        time_d  = time_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE, OVER: begin
                if (se) begin
                    state_d = RUN;
                    cmd_d   = CMD_START;
                    lives_d = LW'(LIVES);
                    time_d  = TW'(ROUND_TIME);
                end
            end
            RUN: begin
                // hit beats timeout beats pause; a hit swallows a same-cycle tick.
                if (hit) begin
                    cmd_d = CMD_DIE;
                    if (lives_q > LW'(1)) begin
                        lives_d = lives_q - LW'(1);
                        resp_d  = RW'(RESPAWN_TICKS);
                        state_d = RESPAWN;
                    end else begin
                        lives_d = '0;
                        state_d = OVER;
                    end
                end else if (tick && (time_q == TW'(1))) begin
                    time_d  = '0;
                    cmd_d   = CMD_DIE;
                    state_d = OVER;
                end else begin
                    if (tick && (time_q != '0)) begin
                        time_d = time_q - TW'(1);
                    end
                    if (pe) begin
                        cmd_d   = CMD_PAUSE;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (pe) begin
                    cmd_d   = CMD_RESUME;
                    state_d = RUN;
                end
            end
            RESPAWN: begin
                if (tick && (resp_q != '0)) begin
                    resp_d = resp_q - RW'(1);
                    if (resp_q == RW'(1)) begin
                        cmd_d   = CMD_START;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        start     = (cmd_q == CMD_START);
        pause     = (cmd_q == CMD_PAUSE);
        resume    = (cmd_q == CMD_RESUME);
        die       = (cmd_q == CMD_DIE);
        lives     = lives_q;
        time_left = time_q;
        game_over = (state_q == OVER);
        sync_err  = sync_err_q;
        dbg_state = state_q;
        exp_sm    = expected_sm(state_q);
        masked    = (cmd_q != CMD_NONE) || (mask_q != 2'd0);
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus random play,
// every command pulse checked against a behavioural game model.
module tb_game_flow_ctrl;

    localparam int LIVES         = 3;
    localparam int ROUND_TIME    = 60;
    localparam int RESPAWN_TICKS = 3;
    localparam int TW            = 8;
    localparam int LW            = 2;
    localparam int EW            = 4 + LW + TW + 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_pause = 1'b0;
    logic          hit       = 1'b0;
    logic          tick      = 1'b0;
    logic          force_sm  = 1'b0;
    logic [1:0]    sm_model;
    logic [1:0]    sm_state;
    logic          start, pause, resume, die, game_over, sync_err;
    logic [LW-1:0] lives;
    logic [TW-1:0] time_left;
    game_pkg::ctrl_state_t dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_RESPAWN, M_OVER} mode_t;
    mode_t    m_mode = M_IDLE;
    int       m_lives = 0, m_time = 0, m_resp = 0;
    logic [4:0] hs = '0, hp = '0;
    logic     m_se, m_pe;

    game_flow_ctrl #(
        .LIVES(LIVES), .ROUND_TIME(ROUND_TIME), .RESPAWN_TICKS(RESPAWN_TICKS), .TW(TW), .LW(LW)
    ) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
        .hit(hit), .tick(tick), .sm_state(sm_state),
        .start(start), .pause(pause), .resume(resume), .die(die),
        .lives(lives), .time_left(time_left), .game_over(game_over),
        .sync_err(sync_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream StateMachine: follows the command pulses.
    always @(posedge clk or negedge reset) begin
        if (!reset)      sm_model <= 2'b00;
        else if (start)  sm_model <= 2'b01;
        else if (pause)  sm_model <= 2'b10;
        else if (resume) sm_model <= 2'b01;
        else if (die)    sm_model <= 2'b11;
    end
    assign sm_state = force_sm ? 2'b00 : sm_model;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_cmd(input logic [3:0] oh);
        logic over;
        over = (m_mode == M_OVER);
        exp_q.push_back({oh, LW'(m_lives), TW'(m_time), over});
    endtask

    // Reference game model; a raw button reaches the game logic as a rise seen
    // three samples late (two sync stages plus the registered edge strobe).
    always @(posedge clk) begin
        if (!reset) begin
            m_mode = M_IDLE; m_lives = 0; m_time = 0; m_resp = 0; hs = '0; hp = '0;
        end else begin
            m_se = hs[2] & ~hs[3];
            m_pe = hp[2] & ~hp[3];
            hs = {hs[3:0], btn_start};
            hp = {hp[3:0], btn_pause};
            case (m_mode)
                M_IDLE, M_OVER: if (m_se) begin
                    m_mode = M_RUN; m_lives = LIVES; m_time = ROUND_TIME;
                    push_cmd(4'b1000);
                end
                M_RUN: if (hit) begin
                    if (m_lives > 0) m_lives--;
                    if (m_lives == 0) m_mode = M_OVER;
                    else begin m_mode = M_RESPAWN; m_resp = RESPAWN_TICKS; end
                    push_cmd(4'b0001);
                end else if (tick && m_time == 1) begin
                    m_time = 0; m_mode = M_OVER;
                    push_cmd(4'b0001);
                end else begin
                    if (tick && m_time > 0) m_time--;
                    if (m_pe) begin m_mode = M_HOLD; push_cmd(4'b0100); end
                end
                M_HOLD: if (m_pe) begin m_mode = M_RUN; push_cmd(4'b0010); end
                M_RESPAWN: if (tick && m_resp > 0) begin
                    m_resp--;
                    if (m_resp == 0) begin m_mode = M_RUN; push_cmd(4'b1000); end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Monitor: every command pulse pops and compares one expected event.
    always @(negedge clk) begin
        if (reset && (start | pause | resume | die)) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {start, pause, resume, die}, 0);
            else check("pulse_event", {start, pause, resume, die, lives, time_left, game_over},
                       exp_q.pop_front());
            check("pulse_onehot", $onehot({start, pause, resume, die}), 1);
        end
    end

    task automatic cyc(input logic h, input logic t);
        hit = h; tick = t;
        @(posedge clk); #1;
        hit = 1'b0; tick = 1'b0;
    endtask

    task automatic press(input int which);
        if (which == 0) btn_start = 1'b1; else btn_pause = 1'b1;
        repeat (4) cyc(0, 0);
        btn_start = 1'b0; btn_pause = 1'b0;
        repeat (4) cyc(0, 0);
    endtask

    task automatic check_state(input string name);
        check({name, "_lives"}, lives, m_lives);
        check({name, "_time"}, time_left, m_time);
        check({name, "_over"}, game_over, (m_mode == M_OVER));
    endtask

    initial begin
        int t0;
        bit seen;
        #1;
        check("rst_pulses", {start, pause, resume, die}, 0);
        check("rst_lives", lives, 0);
        check("rst_time", time_left, 0);
        check("rst_over", game_over, 0);
        check("rst_sync_err", sync_err, 0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) cyc(0, 0);

        // Start and pause/resume
        press(0);
        check("start_lives", lives, 3);
        check("start_time", time_left, 60);
        press(1);
        repeat (5) cyc(0, 1);
        check("hold_time_frozen", time_left, 60);
        press(1);
        cyc(0, 1);
        check("resume_tick", time_left, 59);
        check("resume_sync_err", sync_err, 0);

        // Lose all lives
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0);
            repeat (RESPAWN_TICKS) cyc(0, 1);
            cyc(0, 0);
            check_state("lives_step");
        end
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);

        // Round timeout then restart
        press(0);
        repeat (ROUND_TIME) cyc(0, 1);
        check("timeout_over", game_over, 1);
        check("timeout_time", time_left, 0);
        check("timeout_lives", lives, 3);
        press(0);
        check("restart_lives", lives, 3);
        check("restart_time", time_left, ROUND_TIME);

        // Hit + tick + pause edge together with lives=2
        cyc(1, 0);
        repeat (RESPAWN_TICKS) cyc(0, 1);
        cyc(0, 0);
        check("pre_simul_lives", lives, 2);
        t0 = time_left;
        btn_pause = 1'b1;
        repeat (3) cyc(0, 0);
        cyc(1, 1);
        check("simul_lives", lives, 1);
        check("simul_time", time_left, t0);
        check("simul_over", game_over, 0);
        repeat (4) cyc(0, 0);
        btn_pause = 1'b0;
        repeat (RESPAWN_TICKS) cyc(0, 1);
        repeat (4) cyc(0, 0);
        check_state("post_simul");

        // Random play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 9) == 0) btn_pause = ~btn_pause;
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
            if (i % 100 == 99) check_state("random");
        end
        btn_start = 1'b0; btn_pause = 1'b0;
        repeat (10) cyc(0, 0);
        check_state("random_end");
        check("random_sync_err", sync_err, 0);
        check("queue_drained", exp_q.size(), 0);

        // Desync detection
        reset = 1'b0; #1; exp_q.delete();
        repeat (2) cyc(0, 0);
        reset = 1'b1;
        repeat (2) cyc(0, 0);
        press(0);
        force_sm = 1'b1;
        repeat (6) cyc(0, 0);
        check("desync_set", sync_err, 1);
        force_sm = 1'b0;
        repeat (4) cyc(0, 0);
        check("desync_sticky", sync_err, 1);

        // Reset arriving with a pause pulse in flight
        btn_pause = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (pause) seen = 1;
        end
        check("inflight_pulse_seen", seen, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_pulses", {start, pause, resume, die}, 0);
        check("async_rst_lives", lives, 0);
        check("async_rst_time", time_left, 0);
        check("async_rst_over", game_over, 0);
        check("async_rst_sync_err", sync_err, 0);
        check("async_rst_state", int'(dbg_state), int'(game_pkg::IDLE));
        btn_pause = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
